// File: rtl/jtcop_trace_cap_if.sv
// Bus bundle between the test harness (host/core side) and the frame-triggered trace buffer.
// The master side drives control, probe and read requests; the slave side is the buffer.
interface jtcop_trace_cap_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic          cen;
  logic          vs;
  logic          downloading;
  logic [31:0]   start_frame;
  logic          arm;
  logic          abort;
  logic [DW-1:0] probe;
  logic          rd_req;
  logic [31:0]   frame_cnt;
  logic [1:0]    state;
  logic          full;
  logic [AW:0]   wr_cnt;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_empty;

  modport master (
    output cen, vs, downloading, start_frame, arm, abort, probe, rd_req,
    input  frame_cnt, state, full, wr_cnt, rd_data, rd_valid, rd_empty
  );

  modport slave (
    input  cen, vs, downloading, start_frame, arm, abort, probe, rd_req,
    output frame_cnt, state, full, wr_cnt, rd_data, rd_valid, rd_empty
  );
endinterface

// File: rtl/jtcop_trace_cap.sv
// Frame-triggered trace buffer: counts frames on vs falling edges, captures probe words
// into a simple dual-port RAM starting on a chosen frame, then replays them one per rd_req.
module jtcop_trace_cap #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input logic              clk,
  input logic              rst_n,
  jtcop_trace_cap_if.slave bus
);
  // Handshake: rd_req is a single-cycle request sampled on the clock edge; when accepted,
  // rd_valid pulses for exactly one cycle right after the request cycle with rd_data
  // valid alongside it. There is no backpressure; ignored requests produce no rd_valid.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic          vs_l_q;
  logic [31:0]   frame_cnt_q, frame_cnt_d;
  logic          full_q, full_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_seen_q, rd_seen_d;
  logic [DW-1:0] mem_rd_q;
  logic          fall;
  logic          wr_en;
  logic          rd_en;

  logic [DW-1:0] mem [2**AW];

  assign fall = vs_l_q & ~bus.vs;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    full_d      = full_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    rd_seen_d   = rd_seen_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    if (bus.downloading) begin
      frame_cnt_d = 32'd0;
    end else if (fall) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end

    if (bus.downloading || bus.abort) begin
      state_d = IDLE;
    end else if (bus.arm && state_q != CAPTURE) begin
      state_d  = ARMED;
      wr_cnt_d = '0;
      rd_ptr_d = '0;
      full_d   = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          // Compare against the count before this fall's increment.
          if (fall && frame_cnt_q == bus.start_frame) state_d = CAPTURE;
        end
        CAPTURE: begin
          if (bus.cen) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + ONE;
            if (wr_cnt_q == LAST_IDX) begin
              full_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (bus.rd_req && rd_ptr_q < wr_cnt_q) begin
            rd_en     = 1'b1;
            rd_ptr_d  = rd_ptr_q + ONE;
            rd_seen_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    rd_valid_d = rd_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vs_l_q      <= 1'b0;
      frame_cnt_q <= 32'd0;
      full_q      <= 1'b0;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vs_l_q      <= bus.vs;
      frame_cnt_q <= frame_cnt_d;
      full_q      <= full_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= rd_valid_d;
      rd_seen_q   <= rd_seen_d;
    end
  end

  // Plain synchronous RAM; rd_seen_q masks the unreset read register to zero until first use.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q[AW-1:0]] <= bus.probe;
    if (rd_en) mem_rd_q <= mem[rd_ptr_q[AW-1:0]];
  end

  assign bus.frame_cnt = frame_cnt_q;
  assign bus.state     = state_q;
  assign bus.full      = full_q;
  assign bus.wr_cnt    = wr_cnt_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_seen_q ? mem_rd_q : '0;
  assign bus.rd_empty  = (rd_ptr_q == wr_cnt_q);
endmodule
